sum_request_arbiter: RTL

Round-robin arbiter and sequencer that shares one iterative summation engine among NREQ requesters. Each requester presents an operand A. The block grants one requester at a time, launches the engine, and waits for completion under a watchdog. It then returns the sum, or an error, tagged with the requester ID. It sits between the requester front-ends and the single summation datapath.

---
 rtl/sum_request_arbiter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/sum_request_arbiter.sv
// sum_request_arbiter: round-robin arbiter that shares one iterative
// summation engine among NREQ requesters. One transaction at a time:
// capture winner + operand, launch engine, wait for DONE under a watchdog,
// then return the sum (or an error) tagged with the requester index.
module sum_request_arbiter #(
    parameter int NREQ    = 4,
    parameter int WIDTH   = 10,
    parameter int TIMEOUT = 1100
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [NREQ-1:0]           REQ,
    input  logic [NREQ*WIDTH-1:0]     REQ_A,
    output logic [NREQ-1:0]           GNT,
    output logic                      ENG_START,
    output logic [WIDTH-1:0]          ENG_A,
    output logic                      ENG_ABORT,
    input  logic                      ENG_DONE,
    input  logic [WIDTH-1:0]          ENG_SUM,
    output logic                      RSP_VALID,
    output logic [$clog2(NREQ)-1:0]   RSP_ID,
    output logic [WIDTH-1:0]          RSP_SUM,
    output logic                      RSP_ERR
);
    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_START = 2'b01,
        S_BUSY  = 2'b10,
        S_RESP  = 2'b11
    } state_t;

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [IDW-1:0]   last, last_n;
    logic [IDW-1:0]   cur, cur_n;
    logic [IDW-1:0]   win;
    logic             found;
    logic [NREQ-1:0]  gnt_n;
    logic [WIDTH-1:0] eng_a_n, sum_n;
    logic             start_n, abort_n, vld_n, err_n;
    logic [IDW-1:0]   id_n;

    // Round-robin pick: scan upward from the requester after the last one served.
    always_comb begin
        win   = last;
        found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            int j;
            j = (int'(last) + k) % NREQ;
            if (!found && REQ[j]) begin
                win   = IDW'(j);
                found = 1'b1;
            end
        end
    end

    // Next-state and next-output logic; every output is registered below.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        last_n  = last;
        cur_n   = cur;
        gnt_n   = GNT;
        eng_a_n = ENG_A;
        start_n = 1'b0;
        abort_n = 1'b0;
        vld_n   = 1'b0;
        id_n    = RSP_ID;
        sum_n   = RSP_SUM;
        err_n   = RSP_ERR;
        case (state)
            S_IDLE: begin
                if (found) begin
                    cur_n        = win;
                    gnt_n        = '0;
                    gnt_n[win]   = 1'b1;
                    eng_a_n      = REQ_A[int'(win)*WIDTH +: WIDTH];
                    start_n      = 1'b1;
                    state_n      = S_START;
                end
            end
            S_START: begin
                cnt_n   = '0;
                state_n = S_BUSY;
            end
            S_BUSY: begin
                // DONE wins over a coincident watchdog expiry.
                if (ENG_DONE) begin
                    sum_n   = ENG_SUM;
                    err_n   = 1'b0;
                    vld_n   = 1'b1;
                    id_n    = cur;
                    state_n = S_RESP;
                end else if (cnt == CW'(TIMEOUT - 1)) begin
                    sum_n   = '0;
                    err_n   = 1'b1;
                    abort_n = 1'b1;
                    vld_n   = 1'b1;
                    id_n    = cur;
                    state_n = S_RESP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            S_RESP: begin
                last_n  = cur;
                gnt_n   = '0;
                state_n = S_IDLE;
            end
            default: begin
                gnt_n   = '0;
                state_n = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset leaves requester 0 with first priority.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_IDLE;
            cnt       <= '0;
            last      <= IDW'(NREQ - 1);
            cur       <= '0;
            GNT       <= '0;
            ENG_START <= 1'b0;
            ENG_A     <= '0;
            ENG_ABORT <= 1'b0;
            RSP_VALID <= 1'b0;
            RSP_ID    <= '0;
            RSP_SUM   <= '0;
            RSP_ERR   <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            last      <= last_n;
            cur       <= cur_n;
            GNT       <= gnt_n;
            ENG_START <= start_n;
            ENG_A     <= eng_a_n;
            ENG_ABORT <= abort_n;
            RSP_VALID <= vld_n;
            RSP_ID    <= id_n;
            RSP_SUM   <= sum_n;
            RSP_ERR   <= err_n;
        end
    end
endmodule
